// File: rtl/fp32_add_reg.sv
//------------------------------------------------------------------------------
// Module   : fp32_add_reg
// Purpose  : binary32 adder (round-to-nearest-even) with one output register.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fp32_add_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] number_A,
    input  logic [31:0] number_B,
    output logic        out_valid,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [22:0] mantis
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        a_nan, b_nan, a_inf, b_inf, swap, ovf, rnd_inc;
    logic [31:0] big, sml, res;
    logic [7:0]  big_e, sml_e, diff_e, lim, norm_sh;
    logic [4:0]  align_sh, lzc;
    logic [23:0] big_m, sml_m;
    logic [49:0] sml_ext;
    logic [26:0] big_27, sml_27, norm;
    logic [27:0] raw;
    logic [9:0]  norm_e, exp_pre;
    logic [31:0] packed_r;

    logic        sign_d, sign_q, out_valid_d, out_valid_q;
    logic [7:0]  exp_d, exp_q;
    logic [22:0] mantis_d, mantis_q;

    always_comb begin
        a_nan = (number_A[30:23] == 8'hFF) && (number_A[22:0] != 23'd0);
        b_nan = (number_B[30:23] == 8'hFF) && (number_B[22:0] != 23'd0);
        a_inf = (number_A[30:23] == 8'hFF) && (number_A[22:0] == 23'd0);
        b_inf = (number_B[30:23] == 8'hFF) && (number_B[22:0] == 23'd0);

        // Larger magnitude first; equal magnitudes keep A so results stay symmetric.
        swap  = number_B[30:0] > number_A[30:0];
        big   = swap ? number_B : number_A;
        sml   = swap ? number_A : number_B;
        big_e = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
        sml_e = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
        big_m = {(big[30:23] != 8'd0), big[22:0]};
        sml_m = {(sml[30:23] != 8'd0), sml[22:0]};

        diff_e   = big_e - sml_e;
        align_sh = (diff_e > 8'd26) ? 5'd26 : diff_e[4:0];
        sml_ext  = {sml_m, 26'd0} >> align_sh;
        // Layout: [26:3] significand, [2] guard, [1] round, [0] sticky.
        sml_27   = {sml_ext[49:24], |sml_ext[23:0]};
        big_27   = {big_m, 3'b000};

        if (big[31] == sml[31])
            raw = {1'b0, big_27} + {1'b0, sml_27};
        else
            raw = {1'b0, big_27} - {1'b0, sml_27};

        lzc = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (raw[i])
                lzc = 5'(26 - i);
        end

        lim     = big_e - 8'd1;
        norm_sh = 8'd0;
        if (raw[27]) begin
            norm   = {raw[27:2], raw[1] | raw[0]};
            norm_e = {2'd0, big_e} + 10'd1;
        end else begin
            // Stop the left shift at exponent 1; anything smaller stays subnormal.
            norm_sh = ({3'd0, lzc} < lim) ? {3'd0, lzc} : lim;
            norm    = raw[26:0] << norm_sh;
            norm_e  = {2'd0, big_e} - {2'd0, norm_sh};
        end

        exp_pre  = norm[26] ? norm_e : 10'd0;
        rnd_inc  = norm[2] & (norm[1] | norm[0] | norm[3]);
        // Mantissa carry ripples into the exponent field, covering renormalize and subnormal->normal.
        packed_r = {exp_pre[8:0], norm[25:3]} + {31'd0, rnd_inc};
        ovf      = (exp_pre >= 10'd255) || (packed_r[31:23] >= 9'd255);

        if (raw == 28'd0)
            res = {number_A[31] & number_B[31], 31'd0};
        else if (ovf)
            res = {big[31], 8'hFF, 23'd0};
        else
            res = {big[31], packed_r[30:0]};

        if (a_nan || b_nan || (a_inf && b_inf && (number_A[31] != number_B[31])))
            res = QNAN;
        else if (a_inf)
            res = {number_A[31], 8'hFF, 23'd0};
        else if (b_inf)
            res = {number_B[31], 8'hFF, 23'd0};

        sign_d      = res[31];
        exp_d       = res[30:23];
        mantis_d    = res[22:0];
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q      <= 1'b0;
            exp_q       <= 8'd0;
            mantis_q    <= 23'd0;
            out_valid_q <= 1'b0;
        end else begin
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mantis_q    <= mantis_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sign      = sign_q;
    assign exp       = exp_q;
    assign mantis    = mantis_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fp32_add_reg.sv
//------------------------------------------------------------------------------
// Module   : tb_fp32_add_reg
// Purpose  : scoreboard bench for fp32_add_reg against a double-based reference.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fp32_add_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] number_A, number_B;
    logic        out_valid, sign_o;
    logic [7:0]  exp_o;
    logic [22:0] mantis_o;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];
    logic        exp_v;
    logic [31:0] e_res;

    fp32_add_reg dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .number_A (number_A),
        .number_B (number_B),
        .out_valid(out_valid),
        .sign     (sign_o),
        .exp      (exp_o),
        .mantis   (mantis_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    function automatic real f2r(input logic [31:0] f);
        logic [23:0] m;
        int          e;
        logic [63:0] d;
        m = {(f[30:23] != 8'd0), f[22:0]};
        e = (f[30:23] == 8'd0) ? 1 : int'(f[30:23]);
        if (m == 24'd0) return 0.0;
        while (!m[23]) begin
            m = m << 1;
            e--;
        end
        d = {f[31], 11'(e - 127 + 1023), m[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Double sum rounded once more to binary32 (53 >= 2*24+2 makes this correctly rounded).
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic        an, bn, ai, bi;
        real         rs;
        logic [63:0] d, m, q, rem, half, r;
        int          e, sh, fe;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (an || bn || (ai && bi && a[31] != b[31])) return 32'h7FC0_0000;
        if (ai) return a;
        if (bi) return b;
        rs = f2r(a) + f2r(b);
        if (rs == 0.0)
            return (a == 32'h8000_0000 && b == 32'h8000_0000) ? 32'h8000_0000 : 32'h0;
        d = $realtobits(rs);
        e = int'(d[62:52]) - 1023;
        m = {11'd0, 1'b1, d[51:0]};
        if (e >= -126) begin
            sh = 29;
            fe = e + 127;
        end else begin
            sh = 29 + (-126 - e);
            fe = 0;
        end
        if (sh > 62) sh = 62;
        q    = m >> sh;
        rem  = m & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (fe == 0) r = q;
        else         r = (64'(fe) << 23) + q - 64'h80_0000;
        if (r >= (64'd255 << 23)) return {d[63], 8'hFF, 23'd0};
        return {d[63], r[30:0]};
    endfunction

    function automatic logic [31:0] rnd_op(input logic s, input int e);
        int ec;
        ec = (e < 0) ? 0 : ((e > 253) ? 253 : e);
        return {s, 8'(ec), 23'($urandom)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; number_A = '0; number_B = '0; exp_v = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, sign_o, exp_o, mantis_o} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h, required 0", {out_valid, sign_o, exp_o, mantis_o});
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({out_valid, sign_o, exp_o, mantis_o} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h, required 0", {out_valid, sign_o, exp_o, mantis_o});
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, sign_o, exp_o, mantis_o} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %h, required 0", {out_valid, sign_o, exp_o, mantis_o});
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta[24] = '{
            32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0001, 32'h3F80_0000,
            32'h0000_0001, 32'h0080_0000, 32'h007F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000,
            32'h8000_0000, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0001, 32'h8000_0000,
            32'hBF00_0000, 32'h4000_0000, 32'hBF80_0000, 32'h7F7F_FFFF, 32'h7F7F_FFFF,
            32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h8000_0001};
        logic [31:0] tbv[24] = '{
            32'hBF00_0000, 32'hBF80_0000, 32'h3380_0000, 32'h3380_0000, 32'h3380_0001,
            32'h0000_0001, 32'h8000_0001, 32'h0000_0001, 32'h7F7F_FFFF, 32'hFF80_0000,
            32'h8000_0000, 32'h3F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'h0000_0000,
            32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 32'h7300_0000, 32'h72FF_FFFF,
            32'hB380_0000, 32'hB300_0000, 32'h3F80_0000, 32'h0080_0000};
        logic [31:0] tx[24] = '{
            32'h3F00_0000, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0002, 32'h3F80_0001,
            32'h0000_0002, 32'h007F_FFFF, 32'h0080_0000, 32'h7F80_0000, 32'h7FC0_0000,
            32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h0000_0000,
            32'h3F00_0000, 32'h4080_0000, 32'hC000_0000, 32'h7F80_0000, 32'h7F7F_FFFF,
            32'h3F7F_FFFF, 32'h3F80_0000, 32'h4000_0000, 32'h007F_FFFF};
        for (int i = 0; i <= 25; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== exp_v) begin
                n_fail++;
                $display("FAIL dir_valid[%0d]: got %b, required %b", i, out_valid, exp_v);
            end
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dir_extra[%0d]: got unexpected result, required none", i);
                end else begin
                    e_res = sb_q.pop_front();
                    n_cmp++;
                    if ({sign_o, exp_o, mantis_o} !== e_res) begin
                        n_fail++;
                        $display("FAIL dir_sum[%0d]: got %h, required %h", i, {sign_o, exp_o, mantis_o}, e_res);
                    end
                end
            end
            if (i < 24 && i != 12) begin
                number_A = ta[i]; number_B = tbv[i]; in_valid = 1'b1; exp_v = 1'b1;
                sb_q.push_back(tx[i]);
            end else if (i == 12) begin
                // Idle cycle between valid operands: out_valid must drop.
                number_A = ta[i]; number_B = tbv[i]; in_valid = 1'b0; exp_v = 1'b0;
            end else begin
                in_valid = 1'b0; exp_v = 1'b0;
            end
        end
        // Recover the entry skipped by the idle cycle.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_cmp++;
                if ({sign_o, exp_o, mantis_o} !== tx[12] || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL dir_sum[12]: got %h v=%b, required %h v=1", {sign_o, exp_o, mantis_o}, out_valid, tx[12]);
                end
                in_valid = 1'b0; exp_v = 1'b0;
            end else begin
                number_A = ta[12]; number_B = tbv[12]; in_valid = 1'b1;
            end
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL dir_drain: got %0d pending, required 0", sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_back_to_back(input int n);
        logic [31:0] a, b;
        int          fail0, ea, mode;
        fail0 = n_fail;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== exp_v) begin
                n_fail++;
                $display("FAIL rnd_valid[%0d]: got %b, required %b", i, out_valid, exp_v);
            end
            if (out_valid === 1'b1 && sb_q.size() != 0) begin
                e_res = sb_q.pop_front();
                n_cmp++;
                if ({sign_o, exp_o, mantis_o} !== e_res) begin
                    n_fail++;
                    $display("FAIL rnd_sum[%0d]: A=%h B=%h got %h, required %h",
                             i, number_A, number_B, {sign_o, exp_o, mantis_o}, e_res);
                end
            end
            if (n_fail != fail0 || i == n) begin
                in_valid = 1'b0; exp_v = 1'b0;
                break;
            end
            mode = i % 4;
            ea   = int'($urandom_range(0, 253));
            case (mode)
                0:       begin a = rnd_op(1'b0, ea); b = rnd_op(1'b1, int'($urandom_range(0, 253))); end
                1:       begin a = rnd_op(i[2], ea); b = rnd_op(i[2], int'($urandom_range(0, 253))); end
                2:       begin a = rnd_op(1'b0, ea); b = rnd_op(1'b1, ea + int'($urandom_range(0, 4)) - 2); end
                default: begin a = rnd_op(i[3], ea); b = rnd_op(i[4], ea + int'($urandom_range(0, 2)) - 1); end
            endcase
            number_A = a; number_B = b; in_valid = 1'b1; exp_v = 1'b1;
            sb_q.push_back(ref_add(a, b));
        end
        sb_q.delete();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            number_A = rnd_op(1'b0, 120 + i); number_B = rnd_op(1'b1, 121); in_valid = 1'b1;
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, sign_o, exp_o, mantis_o} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h, required 0", {out_valid, sign_o, exp_o, mantis_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        number_A = 32'h3F80_0000; number_B = 32'hBF00_0000; in_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, sign_o, exp_o, mantis_o} !== {1'b1, 32'h3F00_0000}) begin
            n_fail++;
            $display("FAIL reset_first_sum: got v=%b %h, required v=1 3f000000",
                     out_valid, {sign_o, exp_o, mantis_o});
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back(40000);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
